mpmc11_req_strip_gen: RTL and testbench
=======================================

MPMC11_REQ_STRIP_GEN -- requirements
Module: mpmc11_req_strip_gen

Interface
REQ-001 SHALL have parameter ADDR_WID, default 32, width of memory strip address.
REQ-002 SHALL have parameter STRIP_BYTES, default 16, bytes per strip, power of two.
REQ-003 SHALL have parameter MAX_LEAD, default 2, max accepted data beats ahead of accepted commands.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port state  input  mpmc11_state_t  controller state; IDLE and WRITE_DATA0 are decoded.
REQ-007 SHALL have port addr_base  input  ADDR_WID  start byte address of the write.
REQ-008 SHALL have port num_strips  input  8  index of the last strip (strips to write = num_strips+1).
REQ-009 SHALL have port cmd_rdy  input  1  memory command channel ready.
REQ-010 SHALL have port wdf_rdy  input  1  memory write-data channel ready.
REQ-011 SHALL have port cmd_en  output  1  command offered.
REQ-012 SHALL have port cmd_addr  output  ADDR_WID  address of the offered command.
REQ-013 SHALL have port wdf_wren  output  1  write-data beat offered.
REQ-014 SHALL have port wdf_end  output  1  last beat of strip; equals wdf_wren (one beat per strip).
REQ-015 SHALL have port strip_cnt  output  8  index of the data strip currently offered (selects write data).
REQ-016 SHALL have port done  output  1  one-cycle pulse, all commands and data accepted.

Function
REQ-017 SHALL implement FSM states S_IDLE, S_RUN, S_DONE.
REQ-018 In S_IDLE, on state==WRITE_DATA0 SHALL latch addr_base (low log2(STRIP_BYTES) bits cleared) and num_strips, clear both counters, enter S_RUN next edge.
REQ-019 SHALL keep 9-bit command counter ccnt and data counter dcnt, counting accepted transfers 0..num_strips+1.
REQ-020 cmd_en SHALL be 1 only in S_RUN with ccnt<=num_strips; command accepted on cmd_en&&cmd_rdy, ccnt increments.
REQ-021 cmd_addr SHALL equal latched base + ccnt*STRIP_BYTES, modulo 2^ADDR_WID (wraps, no error).
REQ-022 wdf_wren SHALL be 1 only in S_RUN with dcnt<=num_strips and dcnt<ccnt+MAX_LEAD (registered counts; same-cycle command acceptance not credited).
REQ-023 Data beat accepted on wdf_wren&&wdf_rdy, dcnt increments; strip_cnt SHALL equal dcnt[7:0].
REQ-024 Command and data acceptance in the same cycle SHALL both count.
REQ-025 cmd_en, cmd_addr, wdf_wren, wdf_end, done SHALL be combinational from registered state/counters (offer in first S_RUN cycle, no bubble).
REQ-026 done SHALL be 1 in S_RUN when ccnt==dcnt==num_strips+1; FSM enters S_DONE next edge.
REQ-027 S_DONE SHALL hold outputs low and return to S_IDLE when state==IDLE.
REQ-028 state==IDLE in S_RUN (abort) SHALL return to S_IDLE next edge, clearing counters; outputs low from that cycle.
REQ-029 Changes to addr_base/num_strips while not in S_IDLE SHALL be ignored.

Reset
REQ-030 rst_n==0 at a clock edge SHALL force S_IDLE, ccnt=dcnt=0, latched base/num=0, in any state including mid-run.
REQ-031 After reset, cmd_en, wdf_wren, wdf_end, done, strip_cnt SHALL be 0 and cmd_addr SHALL be 0.

Verification
REQ-032 num_strips=0, base 0x1000, rdys high, WRITE_DATA0 at cycle 0 -> cycle 1 cmd_en=wdf_wren=wdf_end=1, cmd_addr=0x1000; cycle 2 done=1; cycle 3 S_DONE.
REQ-033 num_strips=3, base 0x100F, rdys high -> cmd_addr 0x1000,0x1010,0x1020,0x1030 on consecutive cycles, strip_cnt 0..3, single done pulse.
REQ-034 cmd_rdy=0, wdf_rdy=1 -> exactly 2 beats accepted, then wdf_wren=0; raise cmd_rdy -> transfers resume, all counts reach num_strips+1, done pulses once.
REQ-035 num_strips=255, base 0xFFFFFFF0 -> 256 commands, second cmd_addr 0x00000000, strip_cnt ends at 255, done once.
REQ-036 state forced IDLE after 2 strips accepted -> next cycle cmd_en=wdf_wren=0, strip_cnt=0, no done; new WRITE_DATA0 restarts at strip 0.
REQ-037 rst_n=0 for one cycle mid-run -> next cycle all outputs 0, S_IDLE; later WRITE_DATA0 behaves as REQ-032.

Source files
------------

// File: rtl/mpmc11_req_strip_gen.sv
// Strip write request generator: one command and one data beat per strip,
// with data allowed to run at most MAX_LEAD beats ahead of accepted commands.
package mpmc11_pkg;
    typedef enum logic [2:0] {
        IDLE,
        WRITE_DATA0,
        WRITE_DATA1,
        READ_CMD,
        READ_DATA
    } mpmc11_state_t;
endpackage

module mpmc11_req_strip_gen
    import mpmc11_pkg::*;
#(
    parameter int ADDR_WID    = 32,
    parameter int STRIP_BYTES = 16,
    parameter int MAX_LEAD    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  mpmc11_state_t       state,
    input  logic [ADDR_WID-1:0] addr_base,
    input  logic [7:0]          num_strips,
    input  logic                cmd_rdy,
    input  logic                wdf_rdy,
    output logic                cmd_en,
    output logic [ADDR_WID-1:0] cmd_addr,
    output logic                wdf_wren,
    output logic                wdf_end,
    output logic [7:0]          strip_cnt,
    output logic                done
);

    localparam int SHIFT = $clog2(STRIP_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [ADDR_WID-1:0] base_q, base_d;
    logic [7:0]          num_q, num_d;
    logic [8:0]          ccnt_q, ccnt_d;
    logic [8:0]          dcnt_q, dcnt_d;

    logic                run;
    logic [8:0]          last;
    logic                cmd_fire, wdf_fire;

    assign run  = (fsm_q == S_RUN);
    assign last = {1'b0, num_q} + 9'd1;

    // Outputs depend only on registered state so the first offer lands in the
    // first S_RUN cycle; the data lead is judged against the registered command
    // count, never crediting a command accepted in the same cycle.
    always_comb begin
        cmd_en    = run && (ccnt_q <= {1'b0, num_q});
        wdf_wren  = run && (dcnt_q <= {1'b0, num_q}) &&
                    ({1'b0, dcnt_q} < ({1'b0, ccnt_q} + 10'(MAX_LEAD)));
        wdf_end   = wdf_wren;
        done      = run && (ccnt_q == last) && (dcnt_q == last);
        cmd_addr  = run ? (base_q + (ADDR_WID'(ccnt_q) << SHIFT)) : '0;
        strip_cnt = run ? dcnt_q[7:0] : 8'd0;
    end

    assign cmd_fire = cmd_en && cmd_rdy;
    assign wdf_fire = wdf_wren && wdf_rdy;

    always_comb begin
        fsm_d  = fsm_q;
        base_d = base_q;
        num_d  = num_q;
        ccnt_d = ccnt_q;
        dcnt_d = dcnt_q;
        case (fsm_q)
            S_IDLE: begin
                if (state == WRITE_DATA0) begin
                    base_d = addr_base & ~ADDR_WID'(STRIP_BYTES - 1);
                    num_d  = num_strips;
                    ccnt_d = '0;
                    dcnt_d = '0;
                    fsm_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (state == IDLE) begin
                    ccnt_d = '0;
                    dcnt_d = '0;
                    fsm_d  = S_IDLE;
                end else if (done) begin
                    fsm_d = S_DONE;
                end else begin
                    ccnt_d = ccnt_q + 9'(cmd_fire);
                    dcnt_d = dcnt_q + 9'(wdf_fire);
                end
            end
            S_DONE: begin
                if (state == IDLE) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q  <= S_IDLE;
            base_q <= '0;
            num_q  <= '0;
            ccnt_q <= '0;
            dcnt_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            base_q <= base_d;
            num_q  <= num_d;
            ccnt_q <= ccnt_d;
            dcnt_q <= dcnt_d;
        end
    end

endmodule

// File: tb/tb_mpmc11_req_strip_gen.sv
// Randomized and directed bench for mpmc11_req_strip_gen against a counting
// model of accepted commands and data beats.
module tb_mpmc11_req_strip_gen;
    import mpmc11_pkg::*;

    localparam int AW   = 32;
    localparam int SB   = 16;
    localparam int LEAD = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    mpmc11_state_t st;
    logic [AW-1:0] addr_base;
    logic [7:0]    num_strips;
    logic          cmd_rdy, wdf_rdy;
    logic          cmd_en, wdf_wren, wdf_end, done;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    strip_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: phase 0 idle / 1 running / 2 finished, plus accepted counts.
    int     m_phase, m_num, m_c, m_d;
    longint m_base;
    logic          e_cmd_en, e_wren, e_done;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_strip;

    mpmc11_req_strip_gen #(.ADDR_WID(AW), .STRIP_BYTES(SB), .MAX_LEAD(LEAD)) dut (
        .clk(clk), .rst_n(rst_n), .state(st), .addr_base(addr_base),
        .num_strips(num_strips), .cmd_rdy(cmd_rdy), .wdf_rdy(wdf_rdy),
        .cmd_en(cmd_en), .cmd_addr(cmd_addr), .wdf_wren(wdf_wren),
        .wdf_end(wdf_end), .strip_cnt(strip_cnt), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [43:0] obs();
        return {cmd_en, wdf_wren, wdf_end, done, strip_cnt, cmd_addr};
    endfunction

    function automatic logic [43:0] expv();
        return {e_cmd_en, e_wren, e_wren, e_done, e_strip, e_addr};
    endfunction

    task automatic model_eval();
        bit r;
        r        = (m_phase == 1);
        e_cmd_en = r && (m_c <= m_num);
        e_wren   = r && (m_d <= m_num) && (m_d < m_c + LEAD);
        e_done   = r && (m_c == m_num + 1) && (m_d == m_num + 1);
        e_addr   = r ? AW'(m_base + longint'(m_c) * SB) : '0;
        e_strip  = r ? 8'(m_d % 256) : 8'd0;
    endtask

    task automatic model_commit();
        model_eval();
        if (!rst_n) begin
            m_phase = 0; m_base = 0; m_num = 0; m_c = 0; m_d = 0;
        end else if (m_phase == 0) begin
            if (st == WRITE_DATA0) begin
                m_base  = longint'(addr_base) - (longint'(addr_base) % SB);
                m_num   = int'(num_strips);
                m_c     = 0;
                m_d     = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (st == IDLE) begin
                m_phase = 0; m_c = 0; m_d = 0;
            end else if (e_done) begin
                m_phase = 2;
            end else begin
                if (e_cmd_en && cmd_rdy) m_c++;
                if (e_wren && wdf_rdy) m_d++;
            end
        end else if (st == IDLE) begin
            m_phase = 0;
        end
    endtask

    task automatic adv();
        model_commit();
        @(posedge clk);
        #1;
        model_eval();
    endtask

    task automatic go_idle();
        st = IDLE;
        adv();
        adv();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st = IDLE; addr_base = 32'hDEAD_BEEF; num_strips = 8'd7;
        cmd_rdy = 1'b1; wdf_rdy = 1'b1;
        adv();
        adv();
        rst_n = 1'b1;
        if (obs() !== 44'd0) begin
            n_bad++; $display("FAIL reset_outputs got %h want 0", obs());
        end
        n_cmp++;
        if (obs() !== expv()) begin
            n_bad++; $display("FAIL reset_model got %h want %h", obs(), expv());
        end
        n_cmp++;
    endtask

    task automatic test_single();
        st = WRITE_DATA0; addr_base = 32'h1000; num_strips = 8'd0;
        cmd_rdy = 1'b1; wdf_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL single_c%0d got %h want %h", i, obs(), expv());
            end
            n_cmp++;
            if (i == 1) begin
                if ({cmd_en, wdf_wren, wdf_end, cmd_addr} !== {3'b111, 32'h1000}) begin
                    n_bad++; $display("FAIL single_offer got %b%b%b %h want 111 00001000",
                                      cmd_en, wdf_wren, wdf_end, cmd_addr);
                end
                n_cmp++;
            end
            if (i == 2) begin
                if (done !== 1'b1) begin
                    n_bad++; $display("FAIL single_done got %b want 1", done);
                end
                n_cmp++;
            end
            if (i == 3) begin
                if ({cmd_en, wdf_wren, done} !== 3'b000) begin
                    n_bad++; $display("FAIL single_sdone got %b%b%b want 000", cmd_en, wdf_wren, done);
                end
                n_cmp++;
            end
            adv();
        end
        go_idle();
    endtask

    task automatic test_multi();
        int k, dn;
        k = 0; dn = 0;
        st = WRITE_DATA0; addr_base = 32'h100F; num_strips = 8'd3;
        cmd_rdy = 1'b1; wdf_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL multi_c%0d got %h want %h", i, obs(), expv());
            end
            n_cmp++;
            if (cmd_en) begin
                if (cmd_addr !== 32'h1000 + 32'(k * 16) || strip_cnt !== 8'(k)) begin
                    n_bad++; $display("FAIL multi_addr%0d got %h/%0d want %h/%0d",
                                      k, cmd_addr, strip_cnt, 32'h1000 + 32'(k * 16), k);
                end
                n_cmp++;
                k++;
            end
            dn += int'(done);
            adv();
        end
        if (k != 4 || dn != 1) begin
            n_bad++; $display("FAIL multi_counts got cmds=%0d done=%0d want 4 1", k, dn);
        end
        n_cmp++;
        go_idle();
    endtask

    task automatic test_backpressure();
        int beats, cmds, dn;
        beats = 0; cmds = 0; dn = 0;
        st = WRITE_DATA0; addr_base = 32'h4000; num_strips = 8'd5;
        cmd_rdy = 1'b0; wdf_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL bp_stall_c%0d got %h want %h", i, obs(), expv());
            end
            n_cmp++;
            beats += int'(wdf_wren && wdf_rdy);
            adv();
        end
        if (beats != 2 || wdf_wren !== 1'b0) begin
            n_bad++; $display("FAIL bp_lead got beats=%0d wren=%b want 2 0", beats, wdf_wren);
        end
        n_cmp++;
        cmd_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL bp_resume_c%0d got %h want %h", i, obs(), expv());
            end
            n_cmp++;
            beats += int'(wdf_wren && wdf_rdy);
            cmds  += int'(cmd_en && cmd_rdy);
            dn    += int'(done);
            adv();
        end
        if (beats != 6 || cmds != 6 || dn != 1) begin
            n_bad++; $display("FAIL bp_totals got b=%0d c=%0d d=%0d want 6 6 1", beats, cmds, dn);
        end
        n_cmp++;
        go_idle();
    endtask

    task automatic test_wrap();
        int cmds, dn;
        logic [AW-1:0] a2;
        logic [7:0]    last_sc;
        cmds = 0; dn = 0; a2 = '1; last_sc = '0;
        st = WRITE_DATA0; addr_base = 32'hFFFF_FFF0; num_strips = 8'd255;
        cmd_rdy = 1'b1; wdf_rdy = 1'b1;
        for (int i = 0; i < 262; i++) begin
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL wrap_c%0d got %h want %h", i, obs(), expv());
            end
            n_cmp++;
            if (cmd_en) begin
                if (cmds == 1) a2 = cmd_addr;
                cmds++;
            end
            if (wdf_wren) last_sc = strip_cnt;
            dn += int'(done);
            adv();
        end
        if (cmds != 256 || a2 !== 32'h0 || last_sc !== 8'd255 || dn != 1) begin
            n_bad++; $display("FAIL wrap_totals got c=%0d a2=%h sc=%0d d=%0d want 256 0 255 1",
                              cmds, a2, last_sc, dn);
        end
        n_cmp++;
        go_idle();
    endtask

    task automatic test_abort();
        st = WRITE_DATA0; addr_base = 32'h2000; num_strips = 8'd5;
        cmd_rdy = 1'b1; wdf_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) st = IDLE;
            if (obs() !== expv()) begin
                n_bad++; $display("FAIL abort_c%0d got %h want %h", i, obs(), expv());
            end
            n_cmp++;
            if (i == 4) begin
                if ({cmd_en, wdf_wren, done, strip_cnt} !== 11'd0) begin
                    n_bad++; $display("FAIL abort_quiet got %b%b%b %0d want 000 0",
                                      cmd_en, wdf_wren, done, strip_cnt);
                end
                n_cmp++;
                st = WRITE_DATA0;
            end
            adv();
        end
        if (!(cmd_en === 1'b1 && strip_cnt === 8'd0 && cmd_addr === 32'h2000)) begin
            n_bad++; $display("FAIL abort_restart got en=%b sc=%0d a=%h want 1 0 00002000",
                              cmd_en, strip_cnt, cmd_addr);
        end
        n_cmp++;
        go_idle();
    endtask

    task automatic test_reset_midrun();
        st = WRITE_DATA0; addr_base = 32'h3000; num_strips = 8'd5;
        cmd_rdy = 1'b1; wdf_rdy = 1'b1;
        adv();
        adv();
        adv();
        rst_n = 1'b0; st = IDLE;
        adv();
        rst_n = 1'b1;
        if (obs() !== 44'd0 || obs() !== expv()) begin
            n_bad++; $display("FAIL midreset_outputs got %h want 0", obs());
        end
        n_cmp++;
        test_single();
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            st = WRITE_DATA0;
            addr_base  = $urandom;
            num_strips = 8'($urandom_range(0, 12));
            for (int i = 0; i < 70; i++) begin
                cmd_rdy = 1'($urandom_range(0, 1));
                wdf_rdy = 1'($urandom_range(0, 1));
                st = ($urandom_range(0, 99) == 0) ? IDLE : WRITE_DATA0;
                if (i > 0) begin
                    addr_base  = $urandom;
                    num_strips = 8'($urandom);
                end
                if (obs() !== expv()) begin
                    n_bad++; $display("FAIL rand_t%0d_c%0d got %h want %h", t, i, obs(), expv());
                end
                n_cmp++;
                adv();
            end
            go_idle();
        end
    endtask

    initial begin
        m_phase = 0; m_base = 0; m_num = 0; m_c = 0; m_d = 0;
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_wrap();
        test_abort();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
